// File: rtl/wb_forward_source.sv
// wb_forward_source
//   Producer side of operand forwarding for the 5-stage WISC pipeline.
//   The block carries each result leaving EX through a MEM latch and a WB
//   latch. It drives the register-file write port from the WB latch. For the
//   instruction in decode, it picks the youngest in-flight producer of each
//   source register. When that producer is a load still in EX, it raises a
//   one-cycle load-use stall.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   ex_valid/ex_wr_en/ex_is_load/ex_dst/ex_result
//                               instruction leaving EX this cycle
//   mem_load_data               read data for the load held in the MEM latch
//   hold                        freeze both latches and the retire counter
//   flush                       drop the EX instruction (ignored under hold)
//   id_rs/id_rt, id_*_used      decode source registers and their use flags
//   fwd1_sel/fwd1_data          rs operand source (0 rf,1 EX,2 MEM,3 WB)/value
//   fwd2_sel/fwd2_data          rt operand source/value
//   load_use_stall              decode must stall one cycle
//   wb_en/wb_dst/wb_data        register-file write port
//   retired_cnt                 wrapping count of valid retirements
module wb_forward_source (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_wr_en,
  input  logic        ex_is_load,
  input  logic [2:0]  ex_dst,
  input  logic [15:0] ex_result,
  input  logic [15:0] mem_load_data,
  input  logic        hold,
  input  logic        flush,
  input  logic [2:0]  id_rs,
  input  logic [2:0]  id_rt,
  input  logic        id_rs_used,
  input  logic        id_rt_used,
  output logic [1:0]  fwd1_sel,
  output logic [1:0]  fwd2_sel,
  output logic [15:0] fwd1_data,
  output logic [15:0] fwd2_data,
  output logic        load_use_stall,
  output logic        wb_en,
  output logic [2:0]  wb_dst,
  output logic [15:0] wb_data,
  output logic [15:0] retired_cnt
);

  localparam int DATA_W = 16;

  typedef struct packed {
    logic              stall;
    logic [1:0]        sel;
    logic [DATA_W-1:0] data;
  } fwd_t;

  // MEM latch
  logic              mem_vld_q, mem_vld_d;
  logic              mem_wr_q,  mem_wr_d;
  logic              mem_ld_q,  mem_ld_d;
  logic [2:0]        mem_dst_q, mem_dst_d;
  logic [DATA_W-1:0] mem_res_q, mem_res_d;
  // WB latch
  logic              wb_vld_q,  wb_vld_d;
  logic              wb_wr_q,   wb_wr_d;
  logic [2:0]        wb_dst_q,  wb_dst_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [15:0]       cnt_q,     cnt_d;

  // The value the MEM entry will produce. Loads resolve only once the memory
  // returns data, so the same mux feeds both the WB capture and MEM forwarding.
  logic [DATA_W-1:0] mem_val;
  assign mem_val = mem_ld_q ? mem_load_data : mem_res_q;

  // Youngest producer wins. A matching load in EX cannot supply data yet, so
  // it blocks the older MEM/WB copies and requests a stall instead.
  function automatic fwd_t resolve(input logic used, input logic [2:0] src);
    fwd_t r;
    r = '0;
    if (used) begin
      if (ex_valid && ex_wr_en && ex_dst == src) begin
        if (ex_is_load) r.stall = 1'b1;
        else begin
          r.sel  = 2'd1;
          r.data = ex_result;
        end
      end else if (mem_vld_q && mem_wr_q && mem_dst_q == src) begin
        r.sel  = 2'd2;
        r.data = mem_val;
      end else if (wb_vld_q && wb_wr_q && wb_dst_q == src) begin
        r.sel  = 2'd3;
        r.data = wb_data_q;
      end
    end
    return r;
  endfunction

  fwd_t fwd1, fwd2;
  always_comb begin
    fwd1 = resolve(id_rs_used, id_rs);
    fwd2 = resolve(id_rt_used, id_rt);
  end

  assign fwd1_sel       = fwd1.sel;
  assign fwd1_data      = fwd1.data;
  assign fwd2_sel       = fwd2.sel;
  assign fwd2_data      = fwd2.data;
  assign load_use_stall = fwd1.stall | fwd2.stall;

  // EX -> MEM -> WB stage advance; hold freezes everything, including flush
  always_comb begin
    mem_vld_d = mem_vld_q;
    mem_wr_d  = mem_wr_q;
    mem_ld_d  = mem_ld_q;
    mem_dst_d = mem_dst_q;
    mem_res_d = mem_res_q;
    wb_vld_d  = wb_vld_q;
    wb_wr_d   = wb_wr_q;
    wb_dst_d  = wb_dst_q;
    wb_data_d = wb_data_q;
    cnt_d     = cnt_q;
    if (!hold) begin
      mem_vld_d = ex_valid & ~flush;
      mem_wr_d  = ex_wr_en;
      mem_ld_d  = ex_is_load;
      mem_dst_d = ex_dst;
      mem_res_d = ex_result;
      wb_vld_d  = mem_vld_q;
      wb_wr_d   = mem_wr_q;
      wb_dst_d  = mem_dst_q;
      wb_data_d = mem_val;
      cnt_d     = cnt_q + {15'd0, wb_vld_q};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_vld_q <= 1'b0;
      mem_wr_q  <= 1'b0;
      mem_ld_q  <= 1'b0;
      mem_dst_q <= '0;
      mem_res_q <= '0;
      wb_vld_q  <= 1'b0;
      wb_wr_q   <= 1'b0;
      wb_dst_q  <= '0;
      wb_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      mem_vld_q <= mem_vld_d;
      mem_wr_q  <= mem_wr_d;
      mem_ld_q  <= mem_ld_d;
      mem_dst_q <= mem_dst_d;
      mem_res_q <= mem_res_d;
      wb_vld_q  <= wb_vld_d;
      wb_wr_q   <= wb_wr_d;
      wb_dst_q  <= wb_dst_d;
      wb_data_q <= wb_data_d;
      cnt_q     <= cnt_d;
    end
  end

  // WB stage: write is suppressed while held so the entry is written only once
  assign wb_en       = wb_vld_q & wb_wr_q & ~hold;
  assign wb_dst      = wb_dst_q;
  assign wb_data     = wb_data_q;
  assign retired_cnt = cnt_q;

endmodule

// File: doc/wb_forward_source.md
# wb_forward_source

Result-tracking and write-back block for the 5-stage WISC pipeline. It is the producer side of operand forwarding. It latches each instruction result leaving the execute stage through the EX/MEM and MEM/WB stages, and drives the register-file write port from the MEM/WB entry. It also resolves, for the instruction in decode, which in-flight result (if any) must replace each register-file operand, and raises a load-use stall when that result is not yet available.

## Interface
Parameters:
- none; the register file has 8 registers (3-bit index) and the data width is 16 bits. Register R0 is general-purpose and forwards like any other register.

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- ex_valid  in  1  an instruction is leaving EX this cycle
- ex_wr_en  in  1  that instruction writes a register
- ex_is_load  in  1  that instruction is a load; its data is not known yet
- ex_dst  in  3  destination register of the EX instruction
- ex_result  in  16  ALU output of the EX instruction
- mem_load_data  in  16  memory read data for the load currently in the MEM entry (combinational)
- hold  in  1  freeze both latches (memory busy)
- flush  in  1  discard the EX instruction (branch/jump redirect)
- id_rs, id_rt  in  3 each  source registers of the decode instruction
- id_rs_used, id_rt_used  in  1 each  the source is actually read
- fwd1_sel, fwd2_sel  out  2 each  operand source: 0 regfile, 1 EX, 2 MEM, 3 WB
- fwd1_data, fwd2_data  out  16 each  forwarded value; 0 when the matching sel is 0
- load_use_stall  out  1  decode must stall one cycle
- wb_en  out  1  register-file write enable
- wb_dst  out  3  register-file write index
- wb_data  out  16  register-file write data
- retired_cnt  out  16  count of valid instructions retired from WB

## Operation
State held in two latches:
- MEM latch: {valid, wr_en, is_load, dst, result}
- WB latch: {valid, wr_en, dst, data}

Clocked update (rst_n=1, hold=0):
- MEM latch captures the ex_* inputs. Its valid is ex_valid & ~flush.
- WB latch captures the MEM latch contents. Its data is mem_load_data if MEM.is_load, else MEM.result.
- retired_cnt increments by 1 when WB.valid. It wraps from 0xFFFF to 0x0000.

Hold behaviour:
- When hold=1, both latches and retired_cnt keep their values.
- hold has priority over flush. flush is ignored while hold=1, so the controller keeps flush asserted until hold drops.

Write-back and reset:
- wb_en = WB.valid & WB.wr_en & ~hold.
- wb_dst and wb_data come directly from the WB latch.
- Reset (rst_n=0 at an edge) clears all valid bits, all data and index fields, and retired_cnt to 0. Reset overrides hold and flush.
- After reset, every output is 0: sel=0, data=0, load_use_stall=0, wb_en=0, wb_dst=0, wb_data=0, retired_cnt=0.

Forward resolution (per operand, e.g. rs, combinational, youngest producer wins):
- Consider only operands with id_rs_used=1; otherwise sel=0.
- EX match (ex_valid & ex_wr_en & ex_dst==id_rs):
  - non-load: sel=1, data=ex_result.
  - load: sel=0, data=0, and load_use_stall=1.
- Else MEM match (MEM.valid & MEM.wr_en & MEM.dst==id_rs): sel=2, data=MEM.is_load ? mem_load_data : MEM.result.
- Else WB match: sel=3, data=WB.data. This covers a read of the register being written in the same cycle.
- Else sel=0, data=0.
- The rt operand resolves identically and independently.
- load_use_stall is the OR over both operands.
- Forwarding remains active during hold.
- flush does not mask EX-stage matching. The controller must not rely on forwarding from a flushed instruction.

## Timing
- fwd*, load_use_stall: combinational from the ex_* inputs, the latches, mem_load_data and id_* inputs. There is no register on these paths.
- Result latency: ex_result presented at edge N appears on wb_data after edge N+1 and is written at edge N+2 if hold=0.
- Load latency: mem_load_data sampled at edge N+1 appears as wb_data after edge N+1.
- Stall duration: one cycle. After that the controller presents ex_valid=0 for the bubble, and the load sits in MEM (sel=2).
- Simultaneous flush and ex_valid=1: the MEM entry becomes invalid and no write-back occurs.
- Reset asserted mid-stream: in-flight MEM/WB writes are dropped, with no wb_en pulse on the cycle after the reset edge.

## Test plan
- Reset: hold rst_n=0 for 2 cycles, then release -> all outputs 0, and wb_en stays 0 until a valid instruction retires.
- Back-to-back ALU dependencies:
  - Stimulus: ex_valid=1, ex_wr_en=1, ex_dst=3, ex_result=0x1234; then R3 is used at the next two decodes.
  - Required: cycle 0 sel=1 data 0x1234; cycle 1 sel=2; cycle 2 sel=3 with wb_en=1 wb_dst=3 wb_data=0x1234; retired_cnt=1.
- Load-use:
  - Stimulus: ex_is_load=1, ex_dst=5, and id_rt=5 with id_rt_used=1.
  - Required: load_use_stall=1 and fwd2_sel=0. Next cycle, with mem_load_data=0xBEEF, fwd2_sel=2 and fwd2_data=0xBEEF. One cycle later, wb_data=0xBEEF.
- Priority: EX writes R2=0x0001 while MEM holds R2=0x0002 and WB holds R2=0x0003 -> sel=1, data 0x0001.
- Hold and flush:
  - Hold: with hold=1 for 3 cycles and WB valid, wb_en=0 and retired_cnt is unchanged. After release, exactly one write occurs.
  - Flush: flush=1 with ex_valid=1 (hold=0) -> no write-back 2 cycles later.
- Counter wrap: preload by retiring 65536 valid instructions -> retired_cnt returns to 0x0000.
